data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the ASIP data-memory port. It accepts load/store requests from the core over a valid/ready request channel and returns a valid/ready response.
- Backs addresses with an internal 24-bit word RAM, a small memory-mapped I/O window (free-running cycle counter and a scratch register), and an error response for unmapped addresses.
- Inserts a programmable number of wait states so the core's stall logic can be exercised.

Parameters:
- ADDR_W, 16, request address width (matches core ALU result width)
- DATA_W, 24, data word width (matches core register width)
- DEPTH, 1024, RAM words; addresses 0..DEPTH-1 map to RAM
- WAIT_CYCLES, 2, extra cycles between acceptance and response (0 legal)
- IO_CNT_ADDR, 16'hFFF0, read-only cycle counter address
- IO_SCR_ADDR, 16'hFFF1, read/write scratch register address

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  response available
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  DATA_W  load data (0 for stores and errors)
- rsp_err  out  1  unmapped address or illegal write

Behaviour:
- Clock and reset: single clock `clk`; `reset` is asynchronous and active-high.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, cycle counter=0, scratch=0, wait counter=0. RAM contents are not reset.
- States:
  - IDLE: req_ready=1. Accept on req_valid&&req_ready at edge T: latch write, addr, wdata. Go to WAIT if WAIT_CYCLES>0, else RESP.
  - WAIT: req_ready=0. Count from 0 to WAIT_CYCLES-1, then go to RESP. The first cycle rsp_valid=1 is T+WAIT_CYCLES+1.
  - RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_err stay stable until rsp_valid&&rsp_ready, then return to IDLE (req_ready=1 the next cycle).
- No back-to-back overlap: at most one outstanding request. Maximum throughput is one request per WAIT_CYCLES+2 cycles.
- Address decode, on the latched address:
  - RAM: addr<DEPTH.
  - Counter: addr==IO_CNT_ADDR.
  - Scratch: addr==IO_SCR_ADDR.
  - Anything else is an error.
- Store commit: a RAM or scratch write happens exactly once, on the edge entering RESP. rsp_rdata=0, rsp_err=0.
- Store to the counter: ignored, rsp_err=1.
- Store or load to an unmapped address: no side effect, rsp_err=1, rsp_rdata=0.
- Load: the RAM read is issued on the edge entering RESP and registered, so rsp_rdata is valid with rsp_valid.
  - Counter load returns the counter value sampled on the edge entering RESP.
  - Scratch load returns its current value.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Cycle counter: DATA_W bits, increments every cycle after reset, wraps 2^DATA_W-1 -> 0.
- Inputs are ignored outside IDLE. req_* may change freely while req_ready=0.
- Reset mid-transaction: return to IDLE immediately, drop the pending response, and do not commit a pending store.
- Address width: req_addr is compared at full ADDR_W. RAM is indexed by the low $clog2(DEPTH) bits only after the range check passes.

Decomposition:
- Package asip_mem_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - ADDR_W/DATA_W defaults
  - IO_CNT_ADDR/IO_SCR_ADDR constants
  - decode-result enum (DEC_RAM, DEC_CNT, DEC_SCR, DEC_ERR)
- One sub-module: resp_ram. It is a single-port synchronous RAM (DEPTH x DATA_W, write-enable, registered read, no reset) and is instantiated once.

Test Plan:
- Reset release, WAIT_CYCLES=2: store addr 16'h0005 data 24'hABCDEF accepted at edge T -> rsp_valid=1 at T+3, rsp_err=0, rsp_rdata=0. Then load 16'h0005 -> rsp_rdata=24'hABCDEF.
- Backpressure: load with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable for all 5 cycles; req_ready=0 throughout; req_ready=1 the cycle after the handshake.
- Error cases:
  - Load 16'h0400 (DEPTH) -> rsp_err=1, rsp_rdata=0.
  - Store 16'hFFF0 -> rsp_err=1, and a subsequent counter load is still increasing.
  - Store then load 16'hFFF1 with 24'h000123 -> rsp_rdata=24'h000123.
- Counter: two counter loads accepted 10 cycles apart (WAIT_CYCLES=2) -> values differ by exactly 10.
- Reset asserted in WAIT during a store to 16'h0007 data 24'h111111 (prior contents 24'h222222) -> outputs return to reset values asynchronously; a later load 16'h0007 returns 24'h222222.
- WAIT_CYCLES=0 build: accept at T -> rsp_valid at T+1; with rsp_ready tied 1, three loads complete in 6 cycles.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the ASIP data-memory responder.
package asip_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 24;

    localparam logic [15:0] IO_CNT_ADDR_DEF = 16'hFFF0;
    localparam logic [15:0] IO_SCR_ADDR_DEF = 16'hFFF1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        DEC_RAM,
        DEC_CNT,
        DEC_SCR,
        DEC_ERR
    } dec_e;

    // Full-width address decode; callers zero-extend their operands to 32 bits.
    function automatic dec_e decode(input logic [31:0] addr,
                                    input logic [31:0] depth,
                                    input logic [31:0] cnt_addr,
                                    input logic [31:0] scr_addr);
        dec_e d;
        if (addr < depth)
            d = DEC_RAM;
        else if (addr == cnt_addr)
            d = DEC_CNT;
        else if (addr == scr_addr)
            d = DEC_SCR;
        else
            d = DEC_ERR;
        return d;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channel between the core and the data-memory responder.
interface data_mem_responder_if
    import asip_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_responder_ram.sv
// Single-port synchronous word RAM with registered read and no reset.
module resp_ram #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DATA_W = 24,
    parameter int unsigned AW     = 10
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    // Write or registered read on enabled cycles; output holds otherwise.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we)
                r_mem[i_addr] <= i_wdata;
            else
                r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: RAM, cycle counter, scratch register and error
// responses behind a valid/ready request/response channel with wait states.
module data_mem_responder
    import asip_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W      = ADDR_W_DEF,
    parameter int unsigned       DATA_W      = DATA_W_DEF,
    parameter int unsigned       DEPTH       = 1024,
    parameter int unsigned       WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] IO_CNT_ADDR = ADDR_W'(IO_CNT_ADDR_DEF),
    parameter logic [ADDR_W-1:0] IO_SCR_ADDR = ADDR_W'(IO_SCR_ADDR_DEF)
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);

    localparam int unsigned    RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned    WCW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WCW-1:0] WLAST  = WCW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e            r_state;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              r_rd_ram;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_scr;
    logic [WCW-1:0]    r_wait;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_cur_write;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [DATA_W-1:0] w_cur_wdata;
    dec_e              w_dec;
    logic              w_ram_en;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_q;

    // With no wait states the response is set up on the accept edge itself,
    // so the live request fields are used instead of the latched copies.
    always_comb begin
        w_accept     = (r_state == IDLE) && bus.req_valid;
        w_cur_write  = (r_state == IDLE) ? bus.req_write : r_write;
        w_cur_addr   = (r_state == IDLE) ? bus.req_addr  : r_addr;
        w_cur_wdata  = (r_state == IDLE) ? bus.req_wdata : r_wdata;
        w_enter_resp = ((WAIT_CYCLES == 0) && w_accept) ||
                       ((r_state == WAIT) && (r_wait == WLAST));
        w_dec        = decode(32'(w_cur_addr), 32'(DEPTH),
                              32'(IO_CNT_ADDR), 32'(IO_SCR_ADDR));
        w_ram_en     = w_enter_resp && (w_dec == DEC_RAM);
        w_ram_we     = w_ram_en && w_cur_write;
    end

    resp_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_cur_addr[RAM_AW-1:0]),
        .i_wdata (w_cur_wdata),
        .o_rdata (w_ram_q)
    );

    // Transaction FSM, free-running counter, scratch register and response regs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rd_ram    <= 1'b0;
            r_rdata     <= '0;
            r_cnt       <= '0;
            r_scr       <= '0;
            r_wait      <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_cnt <= r_cnt + DATA_W'(1);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write     <= bus.req_write;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_wait      <= '0;
                        r_req_ready <= 1'b0;
                        // Overridden to RESP below when there are no wait states.
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_wait != WLAST)
                        r_wait <= r_wait + WCW'(1);
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rd_ram    <= 1'b0;
                        r_rdata     <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_enter_resp) begin
                r_state     <= RESP;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b0;
                r_rdata     <= '0;
                r_rd_ram    <= (w_dec == DEC_RAM) && !w_cur_write;
                case (w_dec)
                    DEC_RAM: ;
                    DEC_CNT: begin
                        if (w_cur_write)
                            r_rsp_err <= 1'b1;
                        else
                            r_rdata <= r_cnt;
                    end
                    DEC_SCR: begin
                        if (w_cur_write)
                            r_scr <= w_cur_wdata;
                        else
                            r_rdata <= r_scr;
                    end
                    default: r_rsp_err <= 1'b1;
                endcase
            end
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rd_ram ? w_ram_q : r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one build with two wait states,
// one with none.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst0, rst1;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Edge counter used to timestamp accepts and handshakes.
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();

    logic [1:0]  d_req_valid, d_req_write, d_rsp_ready;
    logic [15:0] d_req_addr  [2];
    logic [23:0] d_req_wdata [2];
    logic [1:0]  o_req_ready, o_rsp_valid, o_rsp_err;
    logic [23:0] o_rdata [2];

    assign bus0.req_valid = d_req_valid[0];
    assign bus0.req_write = d_req_write[0];
    assign bus0.req_addr  = d_req_addr[0];
    assign bus0.req_wdata = d_req_wdata[0];
    assign bus0.rsp_ready = d_rsp_ready[0];
    assign bus1.req_valid = d_req_valid[1];
    assign bus1.req_write = d_req_write[1];
    assign bus1.req_addr  = d_req_addr[1];
    assign bus1.req_wdata = d_req_wdata[1];
    assign bus1.rsp_ready = d_rsp_ready[1];

    assign o_req_ready = {bus1.req_ready, bus0.req_ready};
    assign o_rsp_valid = {bus1.rsp_valid, bus0.rsp_valid};
    assign o_rsp_err   = {bus1.rsp_err,   bus0.rsp_err};
    assign o_rdata[0]  = bus0.rsp_rdata;
    assign o_rdata[1]  = bus1.rsp_rdata;

    data_mem_responder #(.WAIT_CYCLES(2)) u_dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (bus0)
    );

    data_mem_responder #(.WAIT_CYCLES(0)) u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1)
    );

    typedef struct {
        logic [23:0] rdata;
        logic        err;
        bit          cap;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [23:0] cap0[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout/none expected event (t=%0t)", name, $time);
    endtask

    task automatic mon(input int s);
        exp_t e;
        if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
            fail_now($sformatf("rsp_unexpected%0d", s));
        end else begin
            e = (s == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("rsp_err%0d", s), o_rsp_err[s], e.err);
            if (e.cap) begin
                if (s == 0) cap0.push_back(o_rdata[s]);
            end else begin
                check($sformatf("rsp_rdata%0d", s), o_rdata[s], e.rdata);
            end
        end
    endtask

    // Monitor: compare every response on the cycle its handshake completes.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++)
            if (o_rsp_valid[s] && d_rsp_ready[s]) mon(s);
    end

    // Issue one request, hold off rsp_ready for 'hold' response cycles, and
    // return the accept and handshake edge numbers.
    task automatic do_req(input int s, input logic wr, input logic [15:0] addr,
                          input logic [23:0] wd, input logic [23:0] er, input logic ee,
                          input bit cap, input int hold, input int lat_exp,
                          output int acc, output int hs);
        exp_t e;
        bit   accepted;
        bit   seen;
        logic rdy;
        int   lat;
        e.rdata = er;
        e.err   = ee;
        e.cap   = cap;
        if (s == 0) q0.push_back(e); else q1.push_back(e);
        d_req_valid[s] = 1'b1;
        d_req_write[s] = wr;
        d_req_addr[s]  = addr;
        d_req_wdata[s] = wd;
        d_rsp_ready[s] = (hold == 0);
        accepted = 0;
        acc = 0;
        hs = 0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            rdy = o_req_ready[s];
            @(posedge clk);
            if (rdy) accepted = 1;
        end
        #1;
        acc = cyc;
        d_req_valid[s] = 1'b0;
        d_req_write[s] = ~wr;
        d_req_addr[s]  = 16'hFFF1;
        d_req_wdata[s] = 24'h5A5A5A;
        if (!accepted) begin
            fail_now("accept_timeout");
            d_rsp_ready[s] = 1'b1;
            return;
        end
        lat = 0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (o_rsp_valid[s]) seen = 1;
        end
        if (!seen) begin
            fail_now("rsp_timeout");
            d_rsp_ready[s] = 1'b1;
            return;
        end
        check("latency", lat, lat_exp);
        for (int h = 0; h < hold; h++) begin
            if (h > 0) @(negedge clk);
            check("bp_valid", o_rsp_valid[s], 1);
            check("bp_rdata", o_rdata[s], er);
            check("bp_req_ready", o_req_ready[s], 0);
            @(posedge clk);
            #1;
        end
        if (hold > 0) d_rsp_ready[s] = 1'b1;
        @(posedge clk);
        #1;
        hs = cyc;
        if (hold > 0) begin
            @(negedge clk);
            check("ready_after_hs", o_req_ready[s], 1);
            check("valid_after_hs", o_rsp_valid[s], 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state(input int s);
        check($sformatf("rst_req_ready%0d", s), o_req_ready[s], 1);
        check($sformatf("rst_rsp_valid%0d", s), o_rsp_valid[s], 0);
        check($sformatf("rst_rdata%0d", s), o_rdata[s], 0);
        check($sformatf("rst_err%0d", s), o_rsp_err[s], 0);
    endtask

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, h, a1, h3, c1, c2, c3;
        d_req_valid = '0;
        d_req_write = '0;
        d_rsp_ready = '1;
        d_req_addr[0] = '0;
        d_req_addr[1] = '0;
        d_req_wdata[0] = '0;
        d_req_wdata[1] = '0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state(0);
        check_reset_state(1);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(posedge clk);
        #1;

        // Two wait states: store, read back with backpressure, boundaries.
        do_req(0, 1, 16'h0005, 24'hABCDEF, 24'h000000, 0, 0, 0, 3, a, h);
        check("store_hs_edge", h - a, 3);
        do_req(0, 0, 16'h0005, 24'h000000, 24'hABCDEF, 0, 0, 5, 3, a, h);
        do_req(0, 0, 16'h0400, 24'h000000, 24'h000000, 1, 0, 0, 3, a, h);
        do_req(0, 1, 16'h03FF, 24'h00FFFF, 24'h000000, 0, 0, 0, 3, a, h);
        do_req(0, 0, 16'h03FF, 24'h000000, 24'h00FFFF, 0, 0, 0, 3, a, h);
        do_req(0, 0, 16'h1005, 24'h000000, 24'h000000, 1, 0, 0, 3, a, h);
        do_req(0, 1, 16'h8000, 24'h123456, 24'h000000, 1, 0, 0, 3, a, h);

        // Counter loads accepted exactly ten edges apart.
        do_req(0, 0, 16'hFFF0, 24'h000000, 24'h000000, 0, 1, 0, 3, a1, h);
        while (cyc < a1 + 9) begin
            @(posedge clk);
            #1;
        end
        do_req(0, 0, 16'hFFF0, 24'h000000, 24'h000000, 0, 1, 0, 3, a, h);
        check("cnt_accept_gap", a - a1, 10);
        do_req(0, 1, 16'hFFF0, 24'h000005, 24'h000000, 1, 0, 0, 3, a, h);
        do_req(0, 0, 16'hFFF0, 24'h000000, 24'h000000, 0, 1, 0, 3, a, h);
        if (cap0.size() == 3) begin
            c1 = int'(cap0[0]);
            c2 = int'(cap0[1]);
            c3 = int'(cap0[2]);
            check("cnt_delta", 32'((c2 - c1) & 32'hFFFFFF), 10);
            check("cnt_increasing", (c3 > c2), 1);
        end else begin
            fail_now("cnt_captures");
        end

        // Scratch register round trip.
        do_req(0, 1, 16'hFFF1, 24'h000123, 24'h000000, 0, 0, 0, 3, a, h);
        do_req(0, 0, 16'hFFF1, 24'h000000, 24'h000123, 0, 0, 0, 3, a, h);

        // Reset during WAIT must drop the pending store.
        do_req(0, 1, 16'h0007, 24'h222222, 24'h000000, 0, 0, 0, 3, a, h);
        d_req_valid[0] = 1'b1;
        d_req_write[0] = 1'b1;
        d_req_addr[0]  = 16'h0007;
        d_req_wdata[0] = 24'h111111;
        @(negedge clk);
        check("pre_rst_ready", o_req_ready[0], 1);
        @(posedge clk);
        #1;
        d_req_valid[0] = 1'b0;
        @(negedge clk);
        #2;
        rst0 = 1'b1;
        #1;
        check_reset_state(0);
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        do_req(0, 0, 16'h0007, 24'h000000, 24'h222222, 0, 0, 0, 3, a, h);
        do_req(0, 0, 16'h0005, 24'h000000, 24'hABCDEF, 0, 0, 0, 3, a, h);
        do_req(0, 0, 16'hFFF1, 24'h000000, 24'h000000, 0, 0, 0, 3, a, h);

        // No wait states: single-cycle latency and three loads in six edges.
        do_req(1, 1, 16'h0001, 24'hAAAAAA, 24'h000000, 0, 0, 0, 1, a, h);
        do_req(1, 1, 16'h0002, 24'h555555, 24'h000000, 0, 0, 0, 1, a, h);
        do_req(1, 1, 16'h0003, 24'h0F0F0F, 24'h000000, 0, 0, 0, 1, a, h);
        do_req(1, 0, 16'h0001, 24'h000000, 24'hAAAAAA, 0, 0, 0, 1, a1, h);
        do_req(1, 0, 16'h0002, 24'h000000, 24'h555555, 0, 0, 0, 1, a, h);
        do_req(1, 0, 16'h0003, 24'h000000, 24'h0F0F0F, 0, 0, 0, 1, a, h3);
        check("w0_three_loads", h3 - a1, 5);
        do_req(1, 0, 16'h0400, 24'h000000, 24'h000000, 1, 0, 2, 1, a, h);

        repeat (3) @(posedge clk);
        check("queues_drained", q0.size() + q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
